// File: rtl/cpu_pkg.sv
// Shared constants and bundle types for the 16-bit pipelined core.
// Included by every stage; defines the IF/ID bundle layout.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc1;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold and bubble controls.
// Hold beats bubble; a bubble still records the squashed slot's PCs.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int               PC_W = 16,
  parameter logic [15:0]      NOP  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic [15:0]       i_instr,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [PC_W-1:0]   i_pc1,
  output logic [15:0]       o_instr,
  output logic [PC_W-1:0]   o_pc,
  output logic [PC_W-1:0]   o_pc1,
  output logic              o_valid
);

  logic [15:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc1;
  logic            r_valid;

  // Capture, hold, or squash the slot being fetched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_pc1   <= '0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_instr <= r_instr;
      r_pc    <= r_pc;
      r_pc1   <= r_pc1;
      r_valid <= r_valid;
    end else if (i_bubble) begin
      r_instr <= NOP;
      r_pc    <= i_pc;
      r_pc1   <= i_pc1;
      r_valid <= 1'b0;
    end else begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc1   <= i_pc1;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc1   = r_pc1;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, redirect/stall/flush priority, IF/ID.
// Optional HALT freeze enabled by defining FETCH_HALT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic [15:0]       imem_instr,
  output logic [PC_W-1:0]   pc,
  output logic [15:0]       if_id_instr,
  output logic [PC_W-1:0]   if_id_pc,
  output logic [PC_W-1:0]   if_id_pc1,
  output logic              if_id_valid,
  output logic              halted
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_hold;
  logic            w_bubble;
  logic            w_frozen;

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_hold   = stall & ~branch_taken;

`ifdef FETCH_HALT_EN
  logic       r_halted;
  logic [3:0] w_opc;
  logic       w_halt_hit;

  assign w_opc      = imem_instr[OPC_HI:OPC_LO];
  assign w_halt_hit = ~branch_taken & ~stall & ~flush
                    & ~r_halted & (w_opc == OPC_HALT);
  assign w_frozen   = r_halted & ~branch_taken;

  // Latch HALT until a redirect or reset releases fetch
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_halted <= 1'b0;
    else if (branch_taken)
      r_halted <= 1'b0;
    else if (w_halt_hit)
      r_halted <= 1'b1;
  end

  assign halted = r_halted;
`else
  assign w_frozen = 1'b0;
  assign halted   = 1'b0;
`endif

  assign w_bubble = branch_taken | flush | w_frozen;

  // Next PC: redirect, hold on stall/freeze, else advance
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pc <= RESET_PC;
    else if (branch_taken)
      r_pc <= branch_target;
    else if (stall || w_frozen)
      r_pc <= r_pc;
    else
      r_pc <= w_pc_inc;
  end

  assign pc = r_pc;

  if_id_reg #(
    .PC_W (PC_W),
    .NOP  (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (w_hold),
    .i_bubble (w_bubble),
    .i_instr  (imem_instr),
    .i_pc     (r_pc),
    .i_pc1    (w_pc_inc),
    .o_instr  (if_id_instr),
    .o_pc     (if_id_pc),
    .o_pc1    (if_id_pc1),
    .o_valid  (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a cycle model.
// Directed test-plan cases followed by randomized control traffic.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_instr;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        halted;

  logic [15:0] mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  if_id_t m_ifid;
  logic [15:0] m_pc;
  logic        m_halt;

  always #5 clk = ~clk;

  assign imem_instr = mem[pc];

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc1     (if_id_pc1),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic if_id_t bubble_of(input logic [15:0] a);
    if_id_t b;
    b.instr = NOP_INSTR;
    b.pc    = a;
    b.pc1   = a + 16'd1;
    b.valid = 1'b0;
    return b;
  endfunction

  // Apply one clock edge to the model using the pre-edge state.
  task automatic model_edge();
    logic [15:0] fetched;
    fetched = mem[m_pc];
    if (!rst_n) begin
      m_pc   = 16'd0;
      m_ifid = '{instr: NOP_INSTR, pc: 16'd0,
                 pc1: 16'd0, valid: 1'b0};
      m_halt = 1'b0;
    end else if (branch_taken) begin
      m_ifid = bubble_of(m_pc);
      m_pc   = branch_target;
      m_halt = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_halt) begin
      m_ifid = bubble_of(m_pc);
    end else if (flush) begin
      m_ifid = bubble_of(m_pc);
      m_pc   = m_pc + 16'd1;
    end else begin
      m_ifid = '{instr: fetched, pc: m_pc,
                 pc1: m_pc + 16'd1, valid: 1'b1};
      m_pc   = m_pc + 16'd1;
`ifdef FETCH_HALT_EN
      if (fetched[15:12] == 4'hF) m_halt = 1'b1;
`endif
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".pc"},    {16'd0, pc},          {16'd0, m_pc});
    chk({tag, ".instr"}, {16'd0, if_id_instr}, {16'd0, m_ifid.instr});
    chk({tag, ".ipc"},   {16'd0, if_id_pc},    {16'd0, m_ifid.pc});
    chk({tag, ".ipc1"},  {16'd0, if_id_pc1},   {16'd0, m_ifid.pc1});
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_ifid.valid});
    chk({tag, ".halt"},  {31'd0, halted},      {31'd0, m_halt});
  endtask

  task automatic tick(input logic r, input logic s,
                      input logic f, input logic b,
                      input logic [15:0] t, input string tag);
    rst_n         = r;
    stall         = s;
    flush         = f;
    branch_taken  = b;
    branch_target = t;
    @(posedge clk);
    model_edge();
    #1;
    cmp_all(tag);
  endtask

  task automatic go_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, "rst");
  endtask

  logic [15:0] plan [0:8];

  initial begin
    plan[0] = 16'h8040; plan[1] = 16'h8081;
    plan[2] = 16'h0000; plan[3] = 16'h0000;
    plan[4] = 16'h0000; plan[5] = 16'h0298;
    plan[6] = 16'h02A3; plan[7] = 16'h9605;
    plan[8] = 16'h9807;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
`ifdef FETCH_HALT_EN
      if (mem[i][15:12] == 4'hF && $urandom_range(0, 3) != 0)
        mem[i][15:12] = 4'h7;
`endif
    end
    for (int i = 0; i < 9; i++) mem[i] = plan[i];
    mem[16'hFFFF] = 16'h1234;
    m_pc   = 16'd0;
    m_ifid = '0;
    m_halt = 1'b0;

    // Reset state
    go_reset();
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);

    // Free run: test-plan sequence on edges 1..9
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "run");
      chk("plan_instr", {16'd0, if_id_instr}, {16'd0, plan[i]});
      chk("plan_pc", {16'd0, if_id_pc}, i);
      chk("plan_valid", {31'd0, if_id_valid}, 32'd1);
    end

    // Stall at pc=5 for three cycles
    go_reset();
    for (int i = 0; i < 5; i++)
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "pre");
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, (i == 1), 1'b0, 16'h0, "stall");
      chk("stall_pc", {16'd0, pc}, 32'd5);
      chk("stall_ipc", {16'd0, if_id_pc}, 32'd4);
      chk("stall_instr", {16'd0, if_id_instr}, 32'h0000);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "rel");
    chk("rel_instr", {16'd0, if_id_instr}, 32'h0298);

    // Redirect to 7 while stalled
    tick(1'b1, 1'b1, 1'b0, 1'b1, 16'd7, "br");
    chk("br_pc", {16'd0, pc}, 32'd7);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "br2");
    chk("br2_instr", {16'd0, if_id_instr}, 32'h9605);
    chk("br2_pc", {16'd0, if_id_pc}, 32'd7);
    chk("br2_pc1", {16'd0, if_id_pc1}, 32'd8);
    chk("br2_valid", {31'd0, if_id_valid}, 32'd1);

    // Flush alone at pc=1
    go_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "f0");
    tick(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, "flush");
    chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush_instr", {16'd0, if_id_instr}, 32'h0000);
    chk("flush_pc", {16'd0, pc}, 32'd2);

    // Wrap around the top of the address space
    tick(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, "wrap0");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "wrap1");
    chk("wrap_pc", {16'd0, pc}, 32'd0);
    chk("wrap_ipc", {16'd0, if_id_pc}, 32'hFFFF);
    chk("wrap_ipc1", {16'd0, if_id_pc1}, 32'h0000);
    chk("wrap_instr", {16'd0, if_id_instr}, 32'h1234);

    // Reset while stalled
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "w2");
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, "rst_stall");
    chk("rs_pc", {16'd0, pc}, 32'd0);
    chk("rs_ipc1", {16'd0, if_id_pc1}, 32'd0);

`ifdef FETCH_HALT_EN
    mem[3] = 16'hF000;
    go_reset();
    for (int i = 0; i < 6; i++)
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "halt");
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("halt_pc", {16'd0, pc}, 32'd4);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 16'd5, "unhalt");
    chk("halt_clr", {31'd0, halted}, 32'd0);
    mem[3] = 16'h0000;
`endif

    // Randomized control traffic
    go_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           16'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
